regfile_write_sched: RTL and testbench
======================================

Name: regfile_write_sched

Overview:
Write-port scheduler for the 32x32 MIPS register file. The file has a single write port: write_enable, write_reg, write_d.
- After reset, or on a clear request, it sequences a zero-fill of every register.
- In normal operation it shares the write port between two writeback requesters using round-robin arbitration and a valid/ready handshake: req0 is ALU writeback, req1 is load/memory writeback.
- It sits between the writeback stage and the register file.
- Outputs to the register file are registered.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- NREGS, 32, number of registers cleared by the init sequence (must equal 2**ADDR_W).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  one-cycle request to re-run the zero-fill; honoured only in RUN.
- req0_valid  in  1  ALU writeback request.
- req0_addr  in  ADDR_W  destination register.
- req0_data  in  DATA_W  write data.
- req0_ready  out  1  req0 accepted this cycle when req0_valid is also high.
- req1_valid  in  1  load writeback request.
- req1_addr  in  ADDR_W  destination register.
- req1_data  in  DATA_W  write data.
- req1_ready  out  1  req1 accepted this cycle when req1_valid is also high.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  ADDR_W  register file write address (registered).
- rf_wdata  out  DATA_W  register file write data (registered).
- busy  out  1  high while in INIT (combinational from state).

Behaviour:
- Reset asserted (reset=0), asynchronous:
  - state=INIT, init counter=0, last_grant=1 (req0 wins first contention).
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - busy=1, both ready outputs=0.
- Reset asserted mid-operation: same values immediately. Any in-flight registered write is dropped. The init sequence restarts.
- States: INIT and RUN.
- INIT, on each rising edge:
  - rf_we<=1, rf_waddr<=cnt, rf_wdata<=0, cnt<=cnt+1.
  - When cnt==NREGS-1: state<=RUN, cnt<=0.
  - Result: exactly NREGS consecutive write cycles, addresses 0..NREGS-1 in order, all data 0.
- INIT constraints:
  - req0_ready=req1_ready=0; requests are held off, not dropped (the requester keeps valid high).
  - clear is ignored.
- RUN, arbitration (combinational ready outputs):
  - Only one valid: that requester gets ready=1.
  - Both valid: grant the one not equal to last_grant, i.e. strict alternation.
  - At most one ready is high per cycle; a ready is never high without its valid.
- RUN, on an accepted request (valid & ready):
  - Next edge: rf_we<=1, rf_waddr<=addr, rf_wdata<=data, last_grant<=granted index.
  - Latency is 1 cycle from acceptance to the write on the register file port.
  - Back-to-back accepts are allowed, giving one write per cycle at full throughput.
- RUN, on a cycle with no accept: rf_we<=0; rf_waddr and rf_wdata hold their previous values.
- Writes to address 0 ($zero):
  - Accepted normally: ready is asserted and last_grant updates.
  - rf_we<=0 for that cycle, so $zero stays 0.
- clear=1 in RUN:
  - Takes priority over requests: both ready=0 that cycle and no accept occurs.
  - Next edge: state<=INIT, cnt<=0, rf_we<=0.
  - The write accepted in the previous cycle is already on the port and completes.
  - clear and valid in the same cycle: the request is not accepted and must be re-presented after INIT.
- Simultaneous writes to the same address by both requesters: serialized in grant order, so the later grant's data is the final value.
- Arithmetic: cnt is ADDR_W+1 bits wide; its compare with NREGS-1 must not wrap.

Test Plan:
1. Release reset, no requests -> rf_we=1 for exactly 32 cycles with rf_waddr 0..31 and rf_wdata=0. busy=1 throughout, then busy=0 and rf_we=0.
2. RUN, req0_valid with addr=5, data=500 for one cycle -> req0_ready=1 that cycle. Next cycle: rf_we=1, rf_waddr=5, rf_wdata=500. The following cycle: rf_we=0.
3. RUN, both valid continuously (req0 addr=3 data=0xAA, req1 addr=4 data=0xBB) for 4 cycles -> grants go req0, req1, req0, req1. Writes appear on the port one cycle after each grant, with matching addr/data.
4. RUN, req1_valid with addr=0, data=0xFFFF -> req1_ready=1, and rf_we stays 0 the next cycle.
5. RUN, clear=1 together with req0_valid -> req0_ready=0. INIT replays 32 zero writes, then req0 is accepted in the first RUN cycle.
6. Reset pulled low mid-INIT (cnt=10) and mid-RUN while a write is pending -> outputs go to zero immediately and busy=1. After release, the full 32-write init sequence restarts from address 0.

Source files
------------

// File: rtl/regfile_write_sched.sv
// Write-port scheduler for the 32x32 MIPS register file: zero-fills every register
// after reset or clear, then round-robins the single write port between ALU and load writeback.
module regfile_write_sched #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  // One bit wider than the address so the terminal compare can never wrap.
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(NREGS - 1);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                last_grant_q, last_grant_d;
  logic                rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic                grant0, grant1;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    rf_we_d      = 1'b0;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    grant0       = 1'b0;
    grant1       = 1'b0;

    unique case (state_q)
      ST_INIT: begin
        rf_we_d    = 1'b1;
        rf_waddr_d = cnt_q[ADDR_W-1:0];
        rf_wdata_d = '0;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          // Under contention the requester that did not win last time goes first.
          grant0 = req0_valid && (!req1_valid || last_grant_q);
          grant1 = req1_valid && (!req0_valid || !last_grant_q);
          if (grant0) begin
            rf_we_d      = (req0_addr != '0);
            rf_waddr_d   = req0_addr;
            rf_wdata_d   = req0_data;
            last_grant_d = 1'b0;
          end else if (grant1) begin
            rf_we_d      = (req1_addr != '0);
            rf_waddr_d   = req1_addr;
            rf_wdata_d   = req1_data;
            last_grant_d = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      rf_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      rf_we_q      <= rf_we_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign busy       = (state_q == ST_INIT);

endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched: inputs change and outputs are sampled on the
// falling clock edge, expected values are hand-derived constants.
module tb_regfile_write_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  regfile_write_sched #(.ADDR_W(5), .DATA_W(32), .NREGS(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Walk the 32 zero-fill writes; optionally expect req0_ready on the first RUN cycle.
  task automatic check_init_seq(input string tag, input bit req0_held);
    for (int i = 0; i < 32; i++) begin
      tick();
      check($sformatf("%s_we_%0d", tag, i), 32'(rf_we), 32'd1);
      check($sformatf("%s_addr_%0d", tag, i), 32'(rf_waddr), 32'(i));
      check($sformatf("%s_data_%0d", tag, i), rf_wdata, 32'd0);
      check($sformatf("%s_busy_%0d", tag, i), 32'(busy), 32'(i < 31));
      if (req0_held)
        check($sformatf("%s_r0rdy_%0d", tag, i), 32'(req0_ready), 32'(i == 31));
    end
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

    // Reset state
    #3;
    check("rst_we", 32'(rf_we), 32'd0);
    check("rst_addr", 32'(rf_waddr), 32'd0);
    check("rst_data", rf_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_r0rdy", 32'(req0_ready), 32'd0);
    check("rst_r1rdy", 32'(req1_ready), 32'd0);

    // 1: zero-fill after reset release
    tick();
    reset = 1'b1;
    check_init_seq("init1", 1'b0);
    tick();
    check("init1_done_we", 32'(rf_we), 32'd0);
    check("init1_done_busy", 32'(busy), 32'd0);

    // 2: single req0 write, 1-cycle latency
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'd500;
    #1;
    check("t2_r0rdy", 32'(req0_ready), 32'd1);
    check("t2_r1rdy", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    check("t2_we", 32'(rf_we), 32'd1);
    check("t2_addr", 32'(rf_waddr), 32'd5);
    check("t2_data", rf_wdata, 32'd500);
    tick();
    check("t2_we_off", 32'(rf_we), 32'd0);
    check("t2_addr_hold", 32'(rf_waddr), 32'd5);
    check("t2_data_hold", rf_wdata, 32'd500);

    // 4: req1 write to $zero is accepted but suppressed (also hands priority to req0)
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'hFFFF;
    #1;
    check("t4_r1rdy", 32'(req1_ready), 32'd1);
    check("t4_r0rdy", 32'(req0_ready), 32'd0);
    tick();
    req1_valid = 1'b0;
    check("t4_we", 32'(rf_we), 32'd0);

    // 3: both valid -> strict alternation starting with req0
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'hAA;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'hBB;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t3_r0rdy_%0d", k), 32'(req0_ready), 32'(k % 2 == 0));
      check($sformatf("t3_r1rdy_%0d", k), 32'(req1_ready), 32'(k % 2 == 1));
      tick();
      check($sformatf("t3_we_%0d", k), 32'(rf_we), 32'd1);
      check($sformatf("t3_addr_%0d", k), 32'(rf_waddr), (k % 2 == 0) ? 32'd3 : 32'd4);
      check($sformatf("t3_data_%0d", k), rf_wdata, (k % 2 == 0) ? 32'hAA : 32'hBB);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    check("t3_we_off", 32'(rf_we), 32'd0);

    // 5: clear wins over a concurrent request; request held through INIT
    clear = 1'b1;
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'h77;
    #1;
    check("t5_r0rdy_clr", 32'(req0_ready), 32'd0);
    check("t5_busy_clr", 32'(busy), 32'd0);
    tick();
    clear = 1'b0;
    check("t5_we_after_clr", 32'(rf_we), 32'd0);
    check("t5_busy_after_clr", 32'(busy), 32'd1);
    #1;
    check("t5_r0rdy_init", 32'(req0_ready), 32'd0);
    check_init_seq("init5", 1'b1);
    tick();
    req0_valid = 1'b0;
    check("t5_we", 32'(rf_we), 32'd1);
    check("t5_addr", 32'(rf_waddr), 32'd7);
    check("t5_data", rf_wdata, 32'h77);

    // 6a: reset mid-INIT at cnt=10
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("t6a_addr_pre", 32'(rf_waddr), 32'd9);
    reset = 1'b0;
    #1;
    check("t6a_we", 32'(rf_we), 32'd0);
    check("t6a_addr", 32'(rf_waddr), 32'd0);
    check("t6a_data", rf_wdata, 32'd0);
    check("t6a_busy", 32'(busy), 32'd1);
    tick();
    reset = 1'b1;
    check_init_seq("init6a", 1'b0);

    // 6b: reset mid-RUN with a write on the port
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h99;
    #1;
    check("t6b_r1rdy", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    check("t6b_we_pending", 32'(rf_we), 32'd1);
    reset = 1'b0;
    #1;
    check("t6b_we", 32'(rf_we), 32'd0);
    check("t6b_addr", 32'(rf_waddr), 32'd0);
    check("t6b_data", rf_wdata, 32'd0);
    check("t6b_busy", 32'(busy), 32'd1);
    check("t6b_r1rdy_rst", 32'(req1_ready), 32'd0);
    tick();
    reset = 1'b1;
    check_init_seq("init6b", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
